// File: rtl/hazard_if.sv
// Pipeline-to-hazard-unit bundle: register ids, write enables and memory handshake in,
// forward/stall/flush controls and status out.
interface hazard_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        MemErr;
  logic [31:0] StallCount, FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE, PCSrcE,
           RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall, branch flush,
// memory-wait stall with timeout, and stall/flush performance counters.
module hazard_fwd (
  input  logic       rst,
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwm,
  input  logic       regww,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = 2'b00;
    if (!rst) begin
      if (regwm && rdm != 5'd0 && rdm == rs)      fwd = 2'b10;
      else if (regww && rdw != 5'd0 && rdw == rs) fwd = 2'b01;
    end
  end
endmodule

module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);
  localparam int         NUM_SRC = 2;
  localparam logic [7:0] TO      = TIMEOUT[7:0];

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

  state_t      state;
  logic [7:0]  wcnt;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic        lw_stall, mem_stall;

  logic [NUM_SRC-1:0][4:0] rs_e;
  logic [NUM_SRC-1:0][1:0] fwd;

  assign rs_e = {hz.Rs2E, hz.Rs1E};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_fwd
      hazard_fwd u_fwd (
        .rst   (rst),
        .rs    (rs_e[g]),
        .rdm   (hz.RdM),
        .rdw   (hz.RdW),
        .regwm (hz.RegWriteM),
        .regww (hz.RegWriteW),
        .fwd   (fwd[g])
      );
    end
  endgenerate

  assign hz.ForwardAE = fwd[0];
  assign hz.ForwardBE = fwd[1];

  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  // ERROR masks the memory stall so the pipeline can drain after a hung access.
  assign mem_stall = hz.MemReqM && !hz.MemReadyM && (state != ERROR);

  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else begin
        hz.StallF = lw_stall;
        hz.StallD = lw_stall;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = lw_stall || hz.PCSrcE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (hz.StallF && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (hz.FlushD && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (mem_stall) begin
            state <= WAIT;
            wcnt  <= 8'd1;
          end
        end
        WAIT: begin
          if (!hz.MemReqM || hz.MemReadyM) begin
            state <= IDLE;
            wcnt  <= 8'd0;
          end else if (wcnt == TO) begin
            state   <= ERROR;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ERROR:   mem_err <= 1'b1;
        default: state   <= IDLE;
      endcase
    end
  end

  assign hz.MemErr     = mem_err;
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a rule-level reference model, plus literal
// spot checks for forwarding priority, load-use, memory wait, timeout and saturation.
module tb_hazard_ctrl;
  localparam int TOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_if hz();
  hazard_ctrl #(.TIMEOUT(TOUT)) dut (.clk(clk), .rst(rst), .hz(hz));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // reference model state: error flag, consecutive pending-memory cycles, counters
  bit          m_err  = 1'b0;
  int          m_run  = 0;
  logic [31:0] m_scnt = 32'd0;
  logic [31:0] m_fcnt = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    logic [1:0] r;
    r = 2'b00;
    if (rs != 5'd0) begin
      if (hz.RegWriteW && hz.RdW == rs) r = 2'b01;
      if (hz.RegWriteM && hz.RdM == rs) r = 2'b10;
    end
    return r;
  endfunction

  // expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ref_ctl();
    bit lw, ms;
    if (rst) return 7'b0;
    lw = (hz.ResultSrcE == 2'b01) && (hz.RdE != 0) && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    ms = hz.MemReqM && !hz.MemReadyM && !m_err;
    if (ms) return 7'b1111_001;
    return {lw, lw, 1'b0, 1'b0, hz.PCSrcE, lw | hz.PCSrcE, 1'b0};
  endfunction

  always @(posedge clk) begin
    logic [6:0] c;
    c = ref_ctl();
    if (rst) begin
      m_err = 0; m_run = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (c[6] && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      if (c[2] && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      if (!m_err) begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          m_run++;
          if (m_run == TOUT + 1) m_err = 1;
        end else m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] c;
    if (chk_en) begin
      c = ref_ctl();
      check("ForwardAE", {30'd0, hz.ForwardAE}, {30'd0, rst ? 2'b00 : ref_fwd(hz.Rs1E)});
      check("ForwardBE", {30'd0, hz.ForwardBE}, {30'd0, rst ? 2'b00 : ref_fwd(hz.Rs2E)});
      check("stall_flush", {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                            hz.FlushD, hz.FlushE, hz.FlushW}, {25'd0, c});
      check("MemErr", {31'd0, hz.MemErr}, {31'd0, m_err});
      check("StallCount", hz.StallCount, m_scnt);
      check("FlushCount", hz.FlushCount, m_fcnt);
    end
  end

  task automatic quiet();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.ResultSrcE = 2'b00; hz.PCSrcE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] s0, f0;
    quiet();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_stallF", {31'd0, hz.StallF}, 32'd0);
    check("rst_cnt", hz.StallCount, 32'd0);
    next(); rst = 1'b0;

    // forwarding priority: Memory beats Writeback; x0 suppressed
    hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
    @(negedge clk); check("fwd_mem_wins", {30'd0, hz.ForwardAE}, 32'd2);
    next(); hz.RdM = 0;
    @(negedge clk); check("fwd_wb", {30'd0, hz.ForwardAE}, 32'd1);
    next(); quiet(); hz.Rs2E = 0; hz.RdM = 0; hz.RegWriteM = 1;
    @(negedge clk); check("fwd_x0", {30'd0, hz.ForwardBE}, 32'd0);

    // load-use stall
    next(); quiet(); hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7; hz.Rs1D = 3;
    @(negedge clk); s0 = hz.StallCount;
    check("lw_ctl", {28'd0, hz.StallF, hz.StallD, hz.FlushE, hz.FlushD}, 32'b1110);
    next(); @(negedge clk); check("lw_cnt_inc", hz.StallCount - s0, 32'd1);
    next(); hz.RdE = 0; hz.Rs2D = 0;
    @(negedge clk); check("lw_x0", {31'd0, hz.StallF}, 32'd0);

    // load-use together with taken branch
    next(); hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
    @(negedge clk); f0 = hz.FlushCount;
    check("lw_br_ctl", {28'd0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, 32'b1111);
    next(); @(negedge clk); check("br_cnt_inc", hz.FlushCount - f0, 32'd1);

    // memory wait 3 cycles then release, branch held throughout
    next(); quiet(); hz.PCSrcE = 1; hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_ctl", {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                       hz.FlushD, hz.FlushE, hz.FlushW}, 32'b1111_001);
      next();
    end
    hz.MemReadyM = 1;
    @(negedge clk);
    check("mw_release", {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                         hz.FlushD, hz.FlushE, hz.FlushW}, 32'b0000_110);

    // timeout: 1 idle-stall cycle + TOUT wait cycles, then ERROR
    next(); quiet(); hz.MemReqM = 1; hz.MemReadyM = 0;
    for (int i = 0; i < TOUT + 1; i++) begin
      @(negedge clk); check("to_stall", {31'd0, hz.StallF}, 32'd1); next();
    end
    @(negedge clk);
    check("to_err", {30'd0, hz.MemErr, hz.StallF}, 32'b10);
    next(); @(negedge clk); check("to_sticky", {31'd0, hz.MemErr}, 32'd1);
    next(); rst = 1'b1;
    @(negedge clk); check("rst_in_err", {31'd0, hz.StallM}, 32'd0);
    next(); rst = 1'b0; hz.MemReqM = 0;
    @(negedge clk); check("err_cleared", {31'd0, hz.MemErr}, 32'd0);

    // saturation: preload counters near the top, then keep stalling and flushing
    next(); quiet(); hz.ResultSrcE = 2'b01; hz.RdE = 9; hz.Rs1D = 9; hz.PCSrcE = 1;
    @(negedge clk); #1;
    force dut.stall_cnt = 32'hFFFF_FFFD;
    force dut.flush_cnt = 32'hFFFF_FFFE;
    m_scnt = 32'hFFFF_FFFD; m_fcnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    for (int i = 0; i < 4; i++) next();
    @(negedge clk);
    check("sat_stall", hz.StallCount, 32'hFFFF_FFFF);
    check("sat_flush", hz.FlushCount, 32'hFFFF_FFFF);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      next();
      rst           = ($urandom_range(0, 99) < 2);
      hz.Rs1D       = 5'($urandom_range(0, 7));
      hz.Rs2D       = 5'($urandom_range(0, 7));
      hz.Rs1E       = 5'($urandom_range(0, 7));
      hz.Rs2E       = 5'($urandom_range(0, 7));
      hz.RdE        = 5'($urandom_range(0, 7));
      hz.RdM        = 5'($urandom_range(0, 7));
      hz.RdW        = 5'($urandom_range(0, 7));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCSrcE     = ($urandom_range(0, 3) == 0);
      hz.RegWriteM  = $urandom_range(0, 1) != 0;
      hz.RegWriteW  = $urandom_range(0, 1) != 0;
      hz.MemReqM    = ($urandom_range(0, 9) < 5);
      hz.MemReadyM  = ($urandom_range(0, 9) < 4);
    end
    next(); rst = 1'b0; quiet();
    @(negedge clk);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, memory-wait cycle limit before error.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Rs1D, Rs2D  in  5 each  source registers of instruction in Decode.
REQ-005 Rs1E, Rs2E, RdE  in  5 each  source/destination registers in Execute.
REQ-006 ResultSrcE  in  2  Execute result select; 2'b01 marks a load.
REQ-007 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-008 RdM, RdW  in  5 each  destinations in Memory and Writeback.
REQ-009 RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-010 MemReqM  in  1  data-memory access in Memory.
REQ-011 MemReadyM  in  1  data memory completes the access this cycle.
REQ-012 ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 Writeback, 10 Memory.
REQ-013 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
REQ-014 FlushD, FlushE, FlushW  out  1 each  bubble the corresponding pipeline register.
REQ-015 MemErr  out  1  sticky memory-timeout flag.
REQ-016 StallCount, FlushCount  out  32 each  performance counters.

Function
REQ-017 ForwardAE SHALL be 10 if RegWriteM, RdM!=0 and RdM==Rs1E; else 01 if RegWriteW, RdW!=0 and RdW==Rs1E; else 00. Memory wins when both match.
REQ-018 ForwardBE SHALL follow REQ-017 with Rs2E in place of Rs1E.
REQ-019 lwStall = (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-020 memStall = MemReqM & ~MemReadyM & (state!=ERROR).
REQ-021 If memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Memory stall overrides lwStall and PCSrcE, which are re-evaluated after release.
REQ-022 Else: StallF=StallD=lwStall, StallE=StallM=0, FlushD=PCSrcE, FlushE=lwStall|PCSrcE, FlushW=0.
REQ-023 All outputs except the counters and MemErr SHALL be combinational from inputs and current state, with zero latency.
REQ-024 FSM states SHALL be IDLE, WAIT and ERROR, with a registered 8-bit wait counter wcnt.
REQ-025 IDLE: if memStall, go to WAIT with wcnt=1; else stay.
REQ-026 WAIT: if ~MemReqM or MemReadyM, go to IDLE with wcnt=0. Else if wcnt==TIMEOUT, go to ERROR and set MemErr=1. Else increment wcnt.
REQ-027 ERROR SHALL persist until rst; memStall is forced 0 so the pipeline drains; MemErr stays 1.
REQ-028 StallCount SHALL increment on every cycle with StallF=1 and saturate at 32'hFFFFFFFF.
REQ-029 FlushCount SHALL increment on every cycle with FlushD=1 and saturate at 32'hFFFFFFFF.
REQ-030 Register x0 SHALL never cause forwarding or lwStall.

Reset
REQ-031 While rst=1: all stall, flush and forward outputs SHALL be 0; on the next edge the state is IDLE, wcnt=0, MemErr=0 and both counters are 0.
REQ-032 rst asserted during WAIT or ERROR SHALL return to IDLE on the next edge, with no residual stall.

Verification
REQ-033 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; repeat with RdM=0 -> ForwardAE=01.
REQ-034 ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0; StallCount +1 per cycle.
REQ-035 lwStall and PCSrcE=1 together -> FlushD=FlushE=1, StallF=StallD=1; FlushCount +1.
REQ-036 MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 -> 3 cycles with all stalls and FlushW=1; PCSrcE=1 held throughout gives FlushD=1 only on the release cycle.
REQ-037 TIMEOUT=4, MemReadyM held 0 -> ERROR entered after 4 wait cycles, MemErr=1, stalls drop to 0; rst -> MemErr=0 and state IDLE.
REQ-038 Counters preloaded near saturation via a forced stall run -> counter holds at 32'hFFFFFFFF and does not wrap.
